// File: rtl/fxp2fp_pkg.sv
// Shared constants and types for the Q1.7 -> fp32 conversion scheduler.
package fxp2fp_pkg;

   localparam int Q_W        = 8;    // signed Q1.7 sample width
   localparam int FP_W       = 32;   // IEEE-754 single width
   localparam int EXP_W      = 8;
   localparam int MANT_W     = 23;
   localparam int LEAD_W     = $clog2(Q_W);
   // 127 - 7: a leading one at magnitude bit p has weight 2^(p-7)
   localparam int EXP_OFFSET = 120;

   localparam logic [FP_W-1:0] FP_ZERO = '0;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exponent;
      logic [MANT_W-1:0] mantissa;
   } fp32_t;

endpackage

// File: rtl/fxp2fp_sched_if.sv
// Requester-side and result-side handshake bundle of the conversion scheduler.
interface fxp2fp_sched_if #(
   parameter int NREQ = 4,
   parameter int ID_W = $clog2(NREQ)
);

   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;   // requester i at [8i+7:8i]
   logic [NREQ-1:0]   req_ready;
   logic              out_valid;
   logic [31:0]       out_data;
   logic [ID_W-1:0]   out_id;
   logic              out_ready;

   // Traffic source / sink side (requesters plus downstream consumer)
   modport master (
      output req_valid, req_data, out_ready,
      input  req_ready, out_valid, out_data, out_id
   );

   // Scheduler side
   modport slave (
      input  req_valid, req_data, out_ready,
      output req_ready, out_valid, out_data, out_id
   );

endinterface

// File: rtl/fxp8_to_fp32.sv
// Exact combinational conversion of a signed Q1.7 sample to fp32.
module fxp8_to_fp32
   import fxp2fp_pkg::*;
(
   input  logic [Q_W-1:0]  x,
   output logic [FP_W-1:0] f
);

   logic [Q_W-1:0]    mag;
   logic [LEAD_W-1:0] lead;
   logic [FP_W-1:0]   aligned;
   fp32_t             res;

   // Magnitude, leading-one position and left-aligned fraction
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      mag     = x[Q_W-1] ? (~x + Q_W'(1)) : x;   // 0x80 yields 128, as required
      lead    = '0;
      for (int i = 0; i < Q_W; i++) begin
         if (mag[i]) lead = LEAD_W'(i);
      end
      // Shifting the leading one to bit 23 leaves the lower bits as the fraction
      aligned = {{(FP_W-Q_W){1'b0}}, mag} << (MANT_W - int'(lead));
      res.sign     = x[Q_W-1];
      res.exponent = EXP_W'(EXP_OFFSET) + EXP_W'(lead);
      res.mantissa = aligned[MANT_W-1:0];
      f = (x == '0) ? FP_ZERO : res;
   end

endmodule

// File: rtl/fxp2fp_sched.sv
// Round-robin scheduler sharing one two-stage Q1.7 -> fp32 pipeline among NREQ requesters.
module fxp2fp_sched
   import fxp2fp_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int ID_W = $clog2(NREQ)
)(
   input  logic                 clk,
   input  logic                 rst_n,
   fxp2fp_sched_if.slave        bus,
   output logic [15:0]          conv_cnt,
   output logic                 busy
);

   logic             s1_v, s2_v;
   logic [Q_W-1:0]   s1_data;
   logic [ID_W-1:0]  s1_id, s2_id;
   logic [FP_W-1:0]  s2_data, conv_data;
   logic [ID_W-1:0]  rr_ptr, grant, next_ptr, idx;
   logic [Q_W-1:0]   grant_data;
   logic             grant_found, accept;
   logic             s1_en, s2_en;

   assign s2_en  = !s2_v || bus.out_ready;
   assign s1_en  = !s1_v || s2_en;
   assign accept = grant_found && s1_en;

   // Rotating priority search starting at rr_ptr, wrapping modulo NREQ
   always_comb begin
      int sum;
      grant_found = 1'b0;
      grant       = '0;
      idx         = '0;
      sum         = 0;
      for (int k = 0; k < NREQ; k++) begin
         sum = int'(rr_ptr) + k;
         if (sum >= NREQ) sum = sum - NREQ;
         idx = ID_W'(sum);
         if (!grant_found && bus.req_valid[idx]) begin
            grant_found = 1'b1;
            grant       = idx;
         end
      end
   end

   // Select the granted sample and the pointer value that follows the grant
   always_comb begin
      grant_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant == ID_W'(i)) grant_data = bus.req_data[Q_W*i +: Q_W];
      end
      next_ptr = (grant == ID_W'(NREQ-1)) ? '0 : grant + ID_W'(1);
   end

   // Only the granted requester sees ready, and only when S1 can take a sample
   always_comb begin
      bus.req_ready = '0;
      if (accept) bus.req_ready[grant] = 1'b1;
   end

   fxp8_to_fp32 u_conv (
      .x (s1_data),
      .f (conv_data)
   );

   // Pipeline stages, round-robin pointer and delivered-result counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_v     <= 1'b0;
         s1_data  <= '0;
         s1_id    <= '0;
         s2_v     <= 1'b0;
         s2_data  <= FP_ZERO;
         s2_id    <= '0;
         rr_ptr   <= '0;
         conv_cnt <= '0;
      end else begin
         // NOTE: state updates use non-blocking assignment so every register samples pre-edge values.
         if (s1_en) begin
            s1_v <= accept;
            if (accept) begin
               s1_data <= grant_data;
               s1_id   <= grant;
               rr_ptr  <= next_ptr;
            end
         end
         if (s2_en) begin
            s2_v <= s1_v;
            if (s1_v) begin
               s2_data <= conv_data;
               s2_id   <= s1_id;
            end
         end
         if (s2_v && bus.out_ready) conv_cnt <= conv_cnt + 16'd1;
      end
   end

   assign bus.out_valid = s2_v;
   assign bus.out_data  = s2_data;
   assign bus.out_id    = s2_id;
   assign busy          = s1_v || s2_v;

endmodule

// File: tb/tb_fxp2fp_sched.sv
// Self-checking bench for fxp2fp_sched: table vectors, directed corner sequences, random traffic.
module tb_fxp2fp_sched;

   localparam int NREQ = 4;
   localparam int ID_W = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] conv_cnt;
   logic        busy;

   fxp2fp_sched_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

   fxp2fp_sched #(.NREQ(NREQ), .ID_W(ID_W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus.slave),
      .conv_cnt (conv_cnt),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int edges = 0;
   always @(posedge clk) edges++;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct { logic [7:0] x; logic [31:0] fp; } vec_t;
   typedef struct { int id; logic [7:0] x; logic [31:0] fp; } sample_t;
   typedef struct { int id; logic [31:0] fp; int acc; } flight_t;

   sample_t    src[$];
   flight_t    pipe_q[$];
   logic       pend_v[NREQ];
   logic [7:0] pend_x[NREQ];
   logic [31:0] pend_fp[NREQ];
   int         ptr, cnt, last_pop;
   int         valid_pct, ready_pct;
   int         dut_grants[$];
   int         tally[NREQ];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, wanted 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference conversion through the simulator's double format: value = x / 128
   function automatic logic [31:0] fp_ref(input logic [7:0] x);
      real         r;
      logic [63:0] b;
      int          e;
      if (x == 8'h00) return 32'h0;
      r = real'(int'($signed(x))) / 128.0;
      b = $realtobits(r);
      e = int'(b[62:52]) - 1023 + 127;
      return {b[63], e[7:0], b[51:29]};
   endfunction

   function automatic int pending();
      int n = 0;
      for (int i = 0; i < NREQ; i++) if (pend_v[i]) n++;
      return n;
   endfunction

   task automatic add_sample(input int id, input logic [7:0] x, input logic [31:0] fp);
      sample_t s;
      s.id = id; s.x = x; s.fp = fp;
      src.push_back(s);
   endtask

   // One clock of traffic: refill requesters, drive, compare against the model, advance the model
   task automatic step();
      int          g, j;
      logic [NREQ-1:0] exp_rdy;
      logic        vis, s1_free;
      flight_t     f;
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
         if (!pend_v[i] && int'($urandom_range(99)) < valid_pct) begin
            for (int k = 0; k < src.size(); k++) begin
               if (src[k].id == i) begin
                  pend_v[i] = 1'b1; pend_x[i] = src[k].x; pend_fp[i] = src[k].fp;
                  src.delete(k);
                  break;
               end
            end
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         bus.req_valid[i]        = pend_v[i];
         bus.req_data[8*i +: 8]  = pend_x[i];
      end
      bus.out_ready = (int'($urandom_range(99)) < ready_pct);
      #1;
      // The pipeline behaves as a two-entry buffer; the head shows one edge after acceptance
      // or at the edge its predecessor leaves, whichever is later.
      vis = 1'b0;
      if (pipe_q.size() > 0)
         vis = (edges >= pipe_q[0].acc + 1) && (edges >= last_pop);
      s1_free = !(pipe_q.size() == 2 && !bus.out_ready);
      g = -1;
      for (int k = 0; k < NREQ; k++) begin
         j = (ptr + k) % NREQ;
         if (g < 0 && pend_v[j]) g = j;
      end
      exp_rdy = '0;
      if (g >= 0 && s1_free) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      check("out_valid", 32'(bus.out_valid), 32'(vis));
      if (vis) begin
         check("out_data", bus.out_data, pipe_q[0].fp);
         check("out_id", 32'(bus.out_id), 32'(pipe_q[0].id));
      end
      check("conv_cnt", 32'(conv_cnt), 32'(cnt & 16'hFFFF));
      check("busy", 32'(busy), 32'(pipe_q.size() > 0));
      for (int k = 0; k < NREQ; k++)
         if (bus.req_valid[k] && bus.req_ready[k]) dut_grants.push_back(k);
      if (bus.out_valid && bus.out_ready) tally[bus.out_id]++;
      if (vis && bus.out_ready) begin
         void'(pipe_q.pop_front());
         cnt++;
         last_pop = edges + 1;
      end
      if (g >= 0 && s1_free) begin
         f.id = g; f.fp = pend_fp[g]; f.acc = edges + 1;
         pipe_q.push_back(f);
         pend_v[g] = 1'b0;
         ptr = (g + 1) % NREQ;
      end
   endtask

   task automatic drain(input string name);
      int c = 0;
      while ((pipe_q.size() > 0 || src.size() > 0 || pending() > 0) && c < 2000) begin
         step();
         c++;
      end
      check(name, 32'(pipe_q.size() + src.size() + pending()), 32'd0);
   endtask

   task automatic check_grant(input string name, input int k, input int exp);
      if (k < dut_grants.size()) check(name, 32'(dut_grants[k]), 32'(exp));
      else check(name, 32'hFFFF_FFFF, 32'(exp));
   endtask

   task automatic clear_tally();
      for (int i = 0; i < NREQ; i++) tally[i] = 0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[7];
      int   exp_rr[4];
      int   sum;

      vecs[0] = '{x: 8'h40, fp: 32'h3F000000};
      vecs[1] = '{x: 8'h00, fp: 32'h00000000};
      vecs[2] = '{x: 8'h01, fp: 32'h3C000000};
      vecs[3] = '{x: 8'h7F, fp: 32'h3F7E0000};
      vecs[4] = '{x: 8'h80, fp: 32'hBF800000};
      vecs[5] = '{x: 8'hFF, fp: 32'hBC000000};
      vecs[6] = '{x: 8'hC0, fp: 32'hBF000000};
      exp_rr[0] = 3; exp_rr[1] = 1; exp_rr[2] = 3; exp_rr[3] = 1;

      rst_n         = 1'b0;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         pend_v[i] = 1'b0; pend_x[i] = '0; pend_fp[i] = '0;
      end
      clear_tally();
      ptr = 0; cnt = 0; last_pop = 0;
      valid_pct = 100; ready_pct = 100;

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_data", bus.out_data, 32'd0);
      check("rst_out_id", 32'(bus.out_id), 32'd0);
      check("rst_conv_cnt", 32'(conv_cnt), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // All four requesters continuously valid: strict rotation, one grant per cycle
      for (int r = 0; r < 3; r++)
         for (int i = 0; i < NREQ; i++) add_sample(i, 8'($urandom), 32'h0);
      foreach (src[k]) src[k].fp = fp_ref(src[k].x);
      dut_grants.delete();
      clear_tally();
      repeat (12) step();
      check("a4_grant_count", 32'(dut_grants.size()), 32'd12);
      for (int k = 0; k < 12; k++) check_grant("a4_grant_order", k, k % NREQ);
      drain("a4_drain");
      for (int i = 0; i < NREQ; i++) check("a4_results_per_id", 32'(tally[i]), 32'd3);

      // Conversion boundary table through requester 0
      for (int v = 0; v < 7; v++) add_sample(0, vecs[v].x, vecs[v].fp);
      drain("tbl_drain");

      // Only requesters 1 and 3, starting from rr_ptr = 2
      add_sample(1, 8'h11, fp_ref(8'h11));
      drain("rr_setup_drain");
      for (int r = 0; r < 2; r++) begin
         add_sample(1, 8'($urandom), 32'h0);
         add_sample(3, 8'($urandom), 32'h0);
      end
      foreach (src[k]) src[k].fp = fp_ref(src[k].x);
      dut_grants.delete();
      repeat (4) step();
      for (int k = 0; k < 4; k++) check_grant("rr_grant_order", k, exp_rr[k]);
      drain("rr_drain");

      // Backpressure: out_ready low for 5 cycles with all requesters pending
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < NREQ; i++) add_sample(i, 8'($urandom), 32'h0);
      foreach (src[k]) src[k].fp = fp_ref(src[k].x);
      dut_grants.delete();
      clear_tally();
      ready_pct = 0;
      repeat (5) step();
      check("bp_accepted", 32'(dut_grants.size()), 32'd2);
      check("bp_req_ready", 32'(bus.req_ready), 32'd0);
      ready_pct = 100;
      drain("bp_drain");
      sum = 0;
      for (int i = 0; i < NREQ; i++) sum += tally[i];
      check("bp_delivered", 32'(sum), 32'd8);

      // Random traffic with random backpressure
      valid_pct = 60; ready_pct = 70;
      for (int n = 0; n < 200; n++) begin
         logic [7:0] x;
         x = 8'($urandom);
         add_sample(int'($urandom_range(NREQ-1)), x, fp_ref(x));
      end
      drain("rand_drain");

      // Reset with both stages full
      valid_pct = 100; ready_pct = 0;
      for (int r = 0; r < 2; r++) begin
         add_sample(1, 8'($urandom), 32'h0);
         add_sample(2, 8'($urandom), 32'h0);
      end
      foreach (src[k]) src[k].fp = fp_ref(src[k].x);
      repeat (3) step();
      @(negedge clk);
      rst_n = 1'b0;
      bus.req_valid = '0;
      #1;
      check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_conv_cnt", 32'(conv_cnt), 32'd0);
      pipe_q.delete();
      src.delete();
      for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
      ptr = 0; cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      last_pop = edges;
      ready_pct = 100;
      for (int i = 0; i < NREQ; i++) add_sample(i, 8'($urandom), 32'h0);
      foreach (src[k]) src[k].fp = fp_ref(src[k].x);
      dut_grants.delete();
      step();
      check_grant("post_rst_first_grant", 0, 0);
      drain("post_rst_drain");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
